legv8_alu_sequencer: RTL and testbench

Drives the LEGv8 datapath ALU from the control side. It accepts one operation request per valid/ready handshake and translates the opcode into the ALU's FS/Cin encoding. It performs multi-cycle multiplies by iterating the ALU's ADD, then returns the result and status through a response handshake. It also owns the architectural NZCV flag register that conditional branches read.

---
 rtl/legv8_alu_sequencer.sv | 104 ++++++++++
 tb/tb_legv8_alu_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/legv8_alu_sequencer.sv
// legv8_alu_sequencer: handshaked opcode front end for the LEGv8 ALU, with shift-add multiply and NZCV flag register
module legv8_alu_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_setf,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_Cin,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_status,
  output logic             rsp_err,
  output logic [3:0]       flags
);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
  state_t           state;
  logic [3:0]       op;
  logic             setf;
  logic [WIDTH-1:0] a, b, acc, nacc;
  logic [5:0]       cnt;
  logic [4:0]       fs_op;
  logic             legal, mul_done;
  logic [3:0]       mul_status;
  always_comb begin
    fs_op = op == 4'd0 ? 5'b00000 :
            op == 4'd1 ? 5'b00100 :
            op == 4'd2 ? 5'b01100 :
            op == 4'd3 ? 5'b01000 :
            op == 4'd4 ? 5'b01001 :
            op == 4'd5 ? 5'b10000 :
            op == 4'd6 ? 5'b10100 :
            op == 4'd7 ? 5'b00001 : 5'b11000;
    legal = op < 4'd9;
    nacc = b[0] ? alu_F : acc;
    mul_done = (b >> 1) == '0 || cnt == 6'd63;
    mul_status = {2'b00, nacc[WIDTH-1], ~|nacc};
  end
  // In MUL, a holds the shifting multiplicand and b the shifting multiplier
  assign alu_FS    = state == EXEC ? fs_op : state == MUL ? 5'b01000 : 5'b11000;
  assign alu_Cin   = state == EXEC && op == 4'd4;
  assign alu_A     = state == EXEC ? a : state == MUL ? acc : '0;
  assign alu_B     = state == EXEC || state == MUL ? b & {WIDTH{state == EXEC}} | a & {WIDTH{state == MUL}} : '0;
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flags      <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
      op         <= '0;
      setf       <= 1'b0;
      a          <= '0;
      b          <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op    <= req_op;
          a     <= req_a;
          b     <= req_b;
          setf  <= req_setf;
          acc   <= '0;
          cnt   <= '0;
          state <= req_op == 4'd8 ? MUL : EXEC;
        end
        EXEC: begin
          rsp_result <= legal ? alu_F : '0;
          rsp_status <= legal ? alu_status : 4'b0000;
          rsp_err    <= !legal;
          if (setf && legal) flags <= alu_status;
          state      <= RESP;
        end
        MUL: begin
          acc <= nacc;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt + 6'd1;
          if (mul_done) begin
            rsp_result <= nacc;
            rsp_status <= mul_status;
            rsp_err    <= 1'b0;
            if (setf) flags <= mul_status;
            state      <= RESP;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_legv8_alu_sequencer.sv
// tb_legv8_alu_sequencer: directed and random checks of the sequencer against a behavioural ALU and arithmetic reference
module tb_legv8_alu_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_setf = 1'b0;
  logic [3:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [63:0] alu_A, alu_B, alu_F;
  logic [4:0]  alu_FS;
  logic        alu_Cin;
  logic [3:0]  alu_status;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_status, flags;
  int          total = 0, bad = 0;
  logic [3:0]  exp_flags = 4'b0000;
  legv8_alu_sequencer #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_setf(req_setf), .alu_A(alu_A), .alu_B(alu_B),
    .alu_FS(alu_FS), .alu_Cin(alu_Cin), .alu_F(alu_F), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .rsp_err(rsp_err), .flags(flags)
  );
  always #5 clk = ~clk;
  // Behavioural LEGv8 ALU the sequencer drives
  logic [63:0] aa, bb;
  logic [64:0] sum;
  always_comb begin
    aa = alu_FS[1] ? ~alu_A : alu_A;
    bb = alu_FS[0] ? ~alu_B : alu_B;
    sum = {1'b0, aa} + {1'b0, bb} + {64'd0, alu_Cin};
    case (alu_FS[4:2])
      3'd0: alu_F = aa & bb;
      3'd1: alu_F = aa | bb;
      3'd2: alu_F = sum[63:0];
      3'd3: alu_F = aa ^ bb;
      3'd4: alu_F = aa << alu_B[5:0];
      3'd5: alu_F = aa >> alu_B[5:0];
      default: alu_F = '0;
    endcase
    alu_status = {alu_FS[4:2] == 3'd2 && aa[63] == bb[63] && sum[63] != aa[63],
                  alu_FS[4:2] == 3'd2 && sum[64], alu_F[63], alu_F == '0};
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a << b[5:0];
      4'd6: return a >> b[5:0];
      4'd7: return a & ~b;
      4'd8: return a * b;
      default: return 64'd0;
    endcase
  endfunction
  function automatic logic [3:0] ref_status(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [64:0] wide;
    logic c, v;
    r = ref_result(op, a, b);
    wide = {1'b0, a} + {1'b0, b};
    c = op == 4'd3 ? wide[64] : op == 4'd4 ? a >= b : 1'b0;
    v = op == 4'd3 ? (a[63] == b[63] && r[63] != a[63]) :
        op == 4'd4 ? (a[63] != b[63] && r[63] != a[63]) : 1'b0;
    return op > 4'd8 ? 4'b0000 : {v, c, r[63], r == 64'd0};
  endfunction
  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] b);
    int k = 1;
    if (op != 4'd8) return 2;
    for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
    return 1 + k;
  endfunction
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic setf, input int hold);
    int lat;
    logic [63:0] r0;
    logic [3:0] s0;
    @(negedge clk);
    chk({tag, ".req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_setf = setf;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(ref_latency(op, b)));
    if (setf && op <= 4'd8) exp_flags = ref_status(op, a, b);
    chk({tag, ".result"}, rsp_result, ref_result(op, a, b));
    chk({tag, ".status"}, {60'd0, rsp_status}, {60'd0, ref_status(op, a, b)});
    chk({tag, ".err"}, {63'd0, rsp_err}, {63'd0, op > 4'd8});
    chk({tag, ".flags"}, {60'd0, flags}, {60'd0, exp_flags});
    r0 = rsp_result; s0 = rsp_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, ".hold_result"}, rsp_result, r0);
      chk({tag, ".hold_status"}, {60'd0, rsp_status}, {60'd0, s0});
      chk({tag, ".hold_ready"}, {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, ".done_ready"}, {63'd0, req_ready}, 64'd1);
  endtask
  initial begin
    logic [3:0] rop;
    logic [63:0] ra, rb;
    int seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", {63'd0, req_ready}, 64'd0);
    chk("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset.rsp_result", rsp_result, 64'd0);
    chk("reset.rsp_status", {60'd0, rsp_status}, 64'd0);
    chk("reset.rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset.flags", {60'd0, flags}, 64'd0);
    chk("reset.alu_FS", {59'd0, alu_FS}, 64'd24);
    chk("reset.alu_Cin", {63'd0, alu_Cin}, 64'd0);
    chk("reset.alu_A", alu_A, 64'd0);
    chk("reset.alu_B", alu_B, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) if (i != 4) run_op($sformatf("legal%0d", i), 4'(i), 64'd7, 64'd2, 1'b0, 0);
    run_op("sub_neg", 4'd4, 64'd2, 64'd7, 1'b1, 0);
    run_op("sub_zero", 4'd4, 64'd7, 64'd7, 1'b1, 0);
    run_op("mul_7x2", 4'd8, 64'd7, 64'd2, 1'b0, 0);
    run_op("mul_neg", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 0);
    run_op("mul_zero", 4'd8, 64'd12345, 64'd0, 1'b1, 0);
    run_op("mul_max", 4'd8, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 0);
    run_op("illegal", 4'd15, 64'd7, 64'd2, 1'b1, 0);
    run_op("backpressure", 4'd3, 64'd100, 64'd23, 1'b1, 5);
    // Reset in the middle of a long multiply
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd8; req_a = 64'd1; req_b = 64'h8000_0000_0000_0000; req_setf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.req_ready_in_rst", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    exp_flags = 4'b0000;
    @(negedge clk);
    chk("midrst.req_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst.flags", {60'd0, flags}, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      seen += int'(rsp_valid);
      @(negedge clk);
    end
    chk("midrst.no_rsp", 64'(seen), 64'd0);
    run_op("post_rst_add", 4'd3, 64'd7, 64'd2, 1'b0, 0);
    for (int i = 0; i < 25; i++) begin
      rop = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 63);
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
